// File: rtl/regfile_write_sequencer.sv
// regfile_write_sequencer
// Owns the single write port (A3/WD3/WE3) of the register file. The register
// file has no reset of its own. After reset, or on a clr pulse, this block
// scrubs x1..x(REG_NUM-1) to zero. After the scrub it shares the write port
// between core writeback and a debug requester. The core has priority, but a
// starvation guard makes sure debug eventually gets a turn.
//
// Ports
//   clk_i         clock, all state updates on posedge
//   rst_n_i       asynchronous active-low reset
//   clr_i         one-cycle pulse that re-runs the scrub (acted on in RUN only)
//   core_we_i     core writeback request; core_addr_i / core_wdata_i carry it
//   core_stall_o  core write not taken this cycle; core holds its request
//   dbg_req_i     debug write request, held until granted; dbg_addr_i / dbg_wdata_i
//   dbg_gnt_o     debug write performed this cycle
//   rf_we_o       register file WE3
//   rf_a3_o       register file A3
//   rf_wd3_o      register file WD3
//   init_done_o   registered, high while in RUN
//
// state | meaning
// HOLD  | one idle cycle after reset or clr, port quiet, core stalled
// INIT  | scrub: write zero to x(init_cnt), x1 .. x(REG_NUM-1)
// RUN   | arbitrate core writeback vs debug writes
module regfile_write_sequencer #(
    parameter int REG_NUM  = 32,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clr_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wdata_i,
    output logic              core_stall_o,
    input  logic              dbg_req_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_a3_o,
    output logic [DATA_W-1:0] rf_wd3_o,
    output logic              init_done_o
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(REG_NUM - 1);
    localparam logic [ADDR_W-1:0] FIRST_REG = ADDR_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                init_done_q;
    logic                dbg_win;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= HOLD;
            init_cnt_q  <= FIRST_REG;
            wait_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            init_done_q <= (state_d == RUN);
        end
    end

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        wait_cnt_d   = '0;
        dbg_win      = 1'b0;
        rf_we_o      = 1'b0;
        rf_a3_o      = '0;
        rf_wd3_o     = '0;
        core_stall_o = 1'b1;
        dbg_gnt_o    = 1'b0;

        case (state_q)
            HOLD: begin
                state_d    = INIT;
                init_cnt_d = FIRST_REG;
            end

            INIT: begin
                rf_we_o = 1'b1;
                rf_a3_o = init_cnt_q;
                // Counter parks on the last register so it never exceeds it.
                if (init_cnt_q == LAST_REG) begin
                    state_d = RUN;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end

            RUN: begin
                dbg_win      = dbg_req_i && (!core_we_i || (wait_cnt_q == WAIT_MAX));
                core_stall_o = 1'b0;
                if (dbg_win) begin
                    rf_a3_o      = dbg_addr_i;
                    rf_wd3_o     = dbg_wdata_i;
                    dbg_gnt_o    = 1'b1;
                    core_stall_o = core_we_i;
                end else if (core_we_i) begin
                    rf_a3_o  = core_addr_i;
                    rf_wd3_o = core_wdata_i;
                end
                // x0 writes are still granted/accepted, they just never reach WE3.
                rf_we_o = (dbg_win || core_we_i) && (rf_a3_o != '0);

                // A pending request that lost can only have lost to the core, and
                // losing implies wait_cnt is still below MAX_WAIT, so no overflow.
                if (dbg_req_i && !dbg_win) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end

                if (clr_i) begin
                    state_d    = HOLD;
                    init_cnt_d = FIRST_REG;
                end
            end

            default: begin
                state_d    = HOLD;
                init_cnt_d = FIRST_REG;
            end
        endcase
    end

    assign init_done_o = init_done_q;

endmodule
